// File: rtl/cache_controller.sv
// cache_controller
//   Control stage in front of a 128-word direct-mapped data array
//   (32 lines x 4 words). Holds the tag and valid arrays, decodes CPU
//   load/store requests, drives the data-array strobes and the main-memory
//   handshake, and stalls the pipeline on read misses and on stores.
//   Policy: write-through, no-write-allocate.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   mem_read, mem_write  CPU load/store request (held while stall=1)
//   word_addr            CPU word address {tag, index, offset}
//   mm_ready             main memory done (refill data valid on reads)
//   stall                freeze the CPU pipeline
//   cache_read           data-array read strobe
//   cache_update         data-array single-word write strobe
//   cache_refill         data-array 4-word line-fill strobe
//   index_offset         data-array address = word_addr[6:0]
//   mm_read, mm_write    main-memory line read / word write request
//   mm_addr              main-memory address
//   hit_count            saturating read-hit counter
//   miss_count           saturating read-miss counter
module cache_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINES      = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [ADDR_WIDTH-1:0]         word_addr,
  input  logic                          mm_ready,
  output logic                          stall,
  output logic                          cache_read,
  output logic                          cache_update,
  output logic                          cache_refill,
  output logic [$clog2(LINES)+1:0]      index_offset,
  output logic                          mm_read,
  output logic                          mm_write,
  output logic [ADDR_WIDTH-1:0]         mm_addr,
  output logic [CNT_WIDTH-1:0]          hit_count,
  output logic [CNT_WIDTH-1:0]          miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t                        state_q, state_d;
  logic [LINES-1:0]              valid_q;
  logic [LINES-1:0][TAG_W-1:0]   tag_q;
  logic [CNT_WIDTH-1:0]          hit_q, miss_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             fill_en, hit_inc, miss_inc;

  assign tag = word_addr[ADDR_WIDTH-1 -: TAG_W];
  assign idx = word_addr[2 +: IDX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    cache_read   = 1'b0;
    cache_update = 1'b0;
    cache_refill = 1'b0;
    index_offset = '0;
    mm_read      = 1'b0;
    mm_write     = 1'b0;
    mm_addr      = '0;
    fill_en      = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    // Every output is forced low while reset is asserted.
    if (reset) begin
      index_offset = word_addr[IDX_W+1:0];
      unique case (state_q)
        IDLE: begin
          if (mem_write) begin
            stall   = 1'b1;
            state_d = WR_THRU;
          end else if (mem_read) begin
            if (hit) begin
              cache_read = 1'b1;
              hit_inc    = 1'b1;
            end else begin
              stall    = 1'b1;
              miss_inc = 1'b1;
              state_d  = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          stall   = 1'b1;
          mm_read = 1'b1;
          mm_addr = {word_addr[ADDR_WIDTH-1:2], 2'b00};
          if (mm_ready) begin
            cache_refill = 1'b1;
            fill_en      = 1'b1;
            state_d      = IDLE;
          end
        end
        WR_THRU: begin
          mm_write = 1'b1;
          mm_addr  = word_addr;
          stall    = ~mm_ready;
          if (mm_ready) begin
            cache_update = hit;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
      end
      if (hit_inc && hit_q != '1)
        hit_q <= hit_q + 1'b1;
      if (miss_inc && miss_q != '1)
        miss_q <= miss_q + 1'b1;
    end
  end

  assign hit_count  = reset ? hit_q  : '0;
  assign miss_count = reset ? miss_q : '0;

endmodule
